// File: rtl/ysig_pkg.sv
// Shared definitions for the y-vector signature compactor.
// Holds the default widths and MISR constants, the state encoding and the
// fold function that reduces the y vector to one signature-wide word.
package ysig_pkg;

  localparam int unsigned DEF_Y_W   = 284;
  localparam int unsigned DEF_SIG_W = 32;
  localparam int unsigned DEF_CNT_W = 16;
  localparam logic [31:0] DEF_POLY  = 32'h04C1_1DB7;
  localparam logic [31:0] DEF_SEED  = 32'hFFFF_FFFF;

  // Number of signature-wide chunks after zero-extending y
  localparam int unsigned NUM_CHUNKS = (DEF_Y_W + DEF_SIG_W - 1) / DEF_SIG_W;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_WARMUP  = 2'd1;
  localparam state_t ST_COMPACT = 2'd2;
  localparam state_t ST_HOLD    = 2'd3;

  // XOR of all chunks of y, zero-extended to a whole number of chunks
  function automatic logic [DEF_SIG_W-1:0] fold(input logic [DEF_Y_W-1:0] y);
    logic [NUM_CHUNKS*DEF_SIG_W-1:0] ext;
    logic [DEF_SIG_W-1:0]            acc;
    ext              = '0;
    ext[DEF_Y_W-1:0] = y;
    acc              = '0;
    for (int i = 0; i < int'(NUM_CHUNKS); i++) begin
      acc = acc ^ ext[i*DEF_SIG_W +: DEF_SIG_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/ysig_misr_step.sv
// One combinational MISR step (Galois form).
// Ports:
//   sig      current signature
//   fold     folded response word to absorb
//   sig_next signature after shifting, polynomial feedback and absorption
module ysig_misr_step #(
  parameter int unsigned       SIG_W = 32,
  parameter logic [SIG_W-1:0]  POLY  = 32'h04C1_1DB7
) (
  input  logic [SIG_W-1:0] sig,
  input  logic [SIG_W-1:0] fold,
  output logic [SIG_W-1:0] sig_next
);

  always_comb begin
    sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold;
  end

endmodule

// File: rtl/y_sig_compactor.sv
// Compresses the upstream y vector into a MISR signature over a programmed
// window: IDLE -> WARMUP (discard) -> COMPACT (absorb) -> HOLD (handshake).
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   start             begin a run (honoured only in IDLE)
//   warmup_cycles     samples discarded after start
//   compact_cycles    samples absorbed into the signature
//   y_in              response vector
//   busy              high in WARMUP or COMPACT
//   sig_valid         signature available (HOLD)
//   sig_ready         consumer accepts signature
//   sig_out           signature register
// Optional (macro YSIG_CMP_EN): exp_sig input, sig_match / sig_mismatch
// outputs evaluated on the edge that enters HOLD, cleared by start.
// Y_W and SIG_W must match the package defaults used by fold().
module y_sig_compactor
  import ysig_pkg::*;
#(
  parameter int unsigned      Y_W   = DEF_Y_W,
  parameter int unsigned      SIG_W = DEF_SIG_W,
  parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED  = DEF_SEED,
  parameter int unsigned      CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] warmup_cycles,
  input  logic [CNT_W-1:0] compact_cycles,
  input  logic [Y_W-1:0]   y_in,
  output logic             busy,
  output logic             sig_valid,
  input  logic             sig_ready,
  output logic [SIG_W-1:0] sig_out
`ifdef YSIG_CMP_EN
  ,
  input  logic [SIG_W-1:0] exp_sig,
  output logic             sig_match,
  output logic             sig_mismatch
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] warm_q, warm_d;
  logic [CNT_W-1:0] comp_q, comp_d;
  logic [SIG_W-1:0] fold_val;
  logic [SIG_W-1:0] step_next;

  assign fold_val = fold(y_in);

  ysig_misr_step #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_step (
    .sig      (sig_q),
    .fold     (fold_val),
    .sig_next (step_next)
  );

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    warm_d  = warm_q;
    comp_d  = comp_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sig_d  = SEED;
          warm_d = warmup_cycles;
          comp_d = compact_cycles;
          if (warmup_cycles != '0)       state_d = ST_WARMUP;
          else if (compact_cycles != '0) state_d = ST_COMPACT;
          else                           state_d = ST_HOLD;
        end
      end
      ST_WARMUP: begin
        if (warm_q != '0) warm_d = warm_q - CNT_ONE;
        // Leave on the edge that consumes the last warmup cycle
        if (warm_q <= CNT_ONE) state_d = (comp_q != '0) ? ST_COMPACT : ST_HOLD;
      end
      ST_COMPACT: begin
        // y_in only reaches the signature here, so X elsewhere is harmless
        sig_d = step_next;
        if (comp_q != '0) comp_d = comp_q - CNT_ONE;
        if (comp_q <= CNT_ONE) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (sig_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sig_q   <= SEED;
      warm_q  <= '0;
      comp_q  <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      warm_q  <= warm_d;
      comp_q  <= comp_d;
    end
  end

  assign busy      = (state_q == ST_WARMUP) || (state_q == ST_COMPACT);
  assign sig_valid = (state_q == ST_HOLD);
  assign sig_out   = sig_q;

`ifdef YSIG_CMP_EN
  logic hold_entry;
  assign hold_entry = (state_d == ST_HOLD) && (state_q != ST_HOLD);

  // Compare the value being registered on the HOLD entry edge; this takes
  // priority over the start clear when a zero-length run enters HOLD at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_match    <= 1'b0;
      sig_mismatch <= 1'b0;
    end else if (hold_entry) begin
      sig_match    <= (sig_d == exp_sig);
      sig_mismatch <= (sig_d != exp_sig);
    end else if ((state_q == ST_IDLE) && start) begin
      sig_match    <= 1'b0;
      sig_mismatch <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_y_sig_compactor.sv
module tb_y_sig_compactor;

  localparam logic [31:0] POLY = 32'h04C1_1DB7;
  localparam logic [31:0] SEED = 32'hFFFF_FFFF;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [15:0]   warmup_cycles;
  logic [15:0]   compact_cycles;
  logic [283:0]  y_in;
  logic          sig_ready;
  logic          busy, sig_valid, busy_z, sig_valid_z;
  logic [31:0]   sig_out, sig_out_z;
`ifdef YSIG_CMP_EN
  logic [31:0]   exp_sig;
  logic          sig_match, sig_mismatch, sig_match_z, sig_mismatch_z;
`endif

  int total = 0;
  int bad   = 0;

  y_sig_compactor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .warmup_cycles  (warmup_cycles),
    .compact_cycles (compact_cycles),
    .y_in           (y_in),
    .busy           (busy),
    .sig_valid      (sig_valid),
    .sig_ready      (sig_ready),
    .sig_out        (sig_out)
`ifdef YSIG_CMP_EN
    ,
    .exp_sig        (exp_sig),
    .sig_match      (sig_match),
    .sig_mismatch   (sig_mismatch)
`endif
  );

  // Same stimulus, zero seed
  y_sig_compactor #(.SEED(32'h0)) dut_z (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .warmup_cycles  (warmup_cycles),
    .compact_cycles (compact_cycles),
    .y_in           (y_in),
    .busy           (busy_z),
    .sig_valid      (sig_valid_z),
    .sig_ready      (sig_ready),
    .sig_out        (sig_out_z)
`ifdef YSIG_CMP_EN
    ,
    .exp_sig        (exp_sig),
    .sig_match      (sig_match_z),
    .sig_mismatch   (sig_mismatch_z)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each bit b of y lands on signature bit b mod 32
  function automatic logic [31:0] ref_fold(input logic [283:0] y);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 284; b++) r[b % 32] = r[b % 32] ^ y[b];
    return r;
  endfunction

  function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [283:0] y);
    logic [31:0] shifted;
    shifted = s << 1;
    if (s[31]) shifted = shifted ^ POLY;
    return shifted ^ ref_fold(y);
  endfunction

  function automatic logic [283:0] rand_y();
    logic [287:0] v;
    for (int i = 0; i < 9; i++) v[i*32 +: 32] = $urandom;
    return v[283:0];
  endfunction

  // Drive a one-cycle start pulse; returns #1 after the sampling edge
  task automatic pulse_start(input int w, input int c);
    start          = 1'b1;
    warmup_cycles  = 16'(w);
    compact_cycles = 16'(c);
    @(posedge clk); #1;
    start          = 1'b0;
    warmup_cycles  = 16'($urandom);
    compact_cycles = 16'($urandom);
  endtask

  task automatic release_hold();
    sig_ready = 1'b1;
    @(posedge clk); #1;
    sig_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (busy !== 1'b0 || sig_valid !== 1'b0) begin
      bad++; $display("FAIL reset_flags got busy=%b valid=%b want 0 0", busy, sig_valid);
    end
    total++;
    if (sig_out !== SEED) begin
      bad++; $display("FAIL reset_sig got=%h want=%h", sig_out, SEED);
    end
    total++;
    if (sig_out_z !== 32'h0) begin
      bad++; $display("FAIL reset_sig_z got=%h want=%h", sig_out_z, 32'h0);
    end
  endtask

  task automatic test_single_zero();
    y_in = '0;
    pulse_start(0, 1);
    total++;
    if (busy !== 1'b1 || sig_valid !== 1'b0) begin
      bad++; $display("FAIL single_busy got busy=%b valid=%b want 1 0", busy, sig_valid);
    end
    @(posedge clk); #1;
    total++;
    if (sig_valid !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL single_valid got valid=%b busy=%b want 1 0", sig_valid, busy);
    end
    total++;
    if (sig_out !== 32'hFB3E_E249) begin
      bad++; $display("FAIL single_sig got=%h want=%h", sig_out, 32'hFB3E_E249);
    end
    release_hold();
    total++;
    if (sig_valid !== 1'b0 || sig_out !== 32'hFB3E_E249) begin
      bad++; $display("FAIL single_release got valid=%b sig=%h want 0 fb3ee249", sig_valid, sig_out);
    end
  endtask

  task automatic test_seed_zero();
    y_in = 284'd1;
    pulse_start(0, 2);
    @(posedge clk); #1;
    total++;
    if (sig_out_z !== 32'h1) begin
      bad++; $display("FAIL seed0_first got=%h want=%h", sig_out_z, 32'h1);
    end
    @(posedge clk); #1;
    total++;
    if (sig_out_z !== 32'h3 || sig_valid_z !== 1'b1) begin
      bad++; $display("FAIL seed0_hold got sig=%h valid=%b want 3 1", sig_out_z, sig_valid_z);
    end
    release_hold();
  endtask

  task automatic test_chunk8();
    y_in = '0; y_in[256] = 1'b1;
    pulse_start(0, 1);
    @(posedge clk); #1;
    total++;
    if (sig_out_z !== 32'h0000_0001) begin
      bad++; $display("FAIL chunk8_b256 got=%h want=%h", sig_out_z, 32'h1);
    end
    release_hold();
    y_in = '0; y_in[283] = 1'b1;
    pulse_start(0, 1);
    @(posedge clk); #1;
    total++;
    if (sig_out_z !== 32'h0800_0000) begin
      bad++; $display("FAIL chunk8_b283 got=%h want=%h", sig_out_z, 32'h0800_0000);
    end
    release_hold();
  endtask

  task automatic test_warmup_hold();
    int busy_cycles;
    busy_cycles = 0;
    y_in = 'x;
    pulse_start(3, 0);
    for (int i = 0; i < 20 && busy; i++) begin
      busy_cycles++;
      @(posedge clk); #1;
    end
    total++;
    if (busy_cycles != 3) begin
      bad++; $display("FAIL warmup_len got=%0d want=%0d", busy_cycles, 3);
    end
    total++;
    if (sig_valid !== 1'b1 || sig_out !== SEED) begin
      bad++; $display("FAIL warmup_hold got valid=%b sig=%h want 1 %h", sig_valid, sig_out, SEED);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (sig_valid !== 1'b1 || sig_out !== SEED) begin
        bad++; $display("FAIL hold_stable got valid=%b sig=%h want 1 %h", sig_valid, sig_out, SEED);
      end
    end
    release_hold();
    total++;
    if (sig_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL hold_exit got valid=%b busy=%b want 0 0", sig_valid, busy);
    end
  endtask

  task automatic test_abort();
    logic [31:0]  m;
    logic [283:0] y;
    m = SEED;
    y_in = 'x;
    pulse_start(1, 10);
    @(posedge clk); #1;  // warmup edge
    for (int i = 0; i < 3; i++) begin
      y = rand_y(); y_in = y; m = ref_step(m, y);
      if (i == 1) begin
        start = 1'b1; warmup_cycles = 16'd0; compact_cycles = 16'd1;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    total++;
    if (busy !== 1'b1 || sig_out !== m) begin
      bad++; $display("FAIL abort_ignore_start got busy=%b sig=%h want 1 %h", busy, sig_out, m);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || sig_valid !== 1'b0 || sig_out !== SEED) begin
      bad++; $display("FAIL abort_reset got busy=%b valid=%b sig=%h want 0 0 %h",
                      busy, sig_valid, sig_out, SEED);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    y_in = '0;
  endtask

  task automatic test_random();
    logic [31:0]  m, mz;
    logic [283:0] y;
    int w, c;
    for (int run = 0; run < 8; run++) begin
      w = $urandom_range(0, 4);
      c = $urandom_range(0, 12);
      m = SEED; mz = 32'h0;
      y_in = 'x;
      pulse_start(w, c);
      for (int i = 0; i < w; i++) begin
        y_in = 'x;
        @(posedge clk); #1;
      end
      for (int i = 0; i < c; i++) begin
        y = rand_y(); y_in = y;
        m = ref_step(m, y); mz = ref_step(mz, y);
        @(posedge clk); #1;
      end
      y_in = 'x;
      total++;
      if (sig_valid !== 1'b1 || busy !== 1'b0) begin
        bad++; $display("FAIL rand_valid run=%0d got valid=%b busy=%b want 1 0", run, sig_valid, busy);
      end
      total++;
      if (sig_out !== m || sig_out_z !== mz) begin
        bad++; $display("FAIL rand_sig run=%0d w=%0d c=%0d got=%h/%h want=%h/%h",
                        run, w, c, sig_out, sig_out_z, m, mz);
      end
      release_hold();
    end
    y_in = '0;
  endtask

`ifdef YSIG_CMP_EN
  task automatic test_compare();
    y_in = '0;
    exp_sig = 32'hFB3E_E249;
    pulse_start(0, 1);
    @(posedge clk); #1;
    total++;
    if (sig_match !== 1'b1 || sig_mismatch !== 1'b0) begin
      bad++; $display("FAIL cmp_match got m=%b mm=%b want 1 0", sig_match, sig_mismatch);
    end
    release_hold();
    exp_sig = 32'h0;
    pulse_start(1, 1);
    total++;
    if (sig_match !== 1'b0 || sig_mismatch !== 1'b0) begin
      bad++; $display("FAIL cmp_clear got m=%b mm=%b want 0 0", sig_match, sig_mismatch);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (sig_match !== 1'b0 || sig_mismatch !== 1'b1) begin
      bad++; $display("FAIL cmp_mismatch got m=%b mm=%b want 0 1", sig_match, sig_mismatch);
    end
    release_hold();
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; sig_ready = 1'b0;
    warmup_cycles = '0; compact_cycles = '0; y_in = '0;
`ifdef YSIG_CMP_EN
    exp_sig = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_single_zero();
    test_seed_zero();
    test_chunk8();
    test_warmup_hold();
    test_abort();
    test_random();
`ifdef YSIG_CMP_EN
    test_compare();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
